// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath.
//   mac_state_e        : accumulator FSM states (ACCUM collects beats, HOLD
//                        presents a finished frame result).
//   MAC_PRODUCT_WIDTH  : default product width from the upstream multiplier.
//   MAC_ACC_WIDTH      : default accumulator / output sum width.
package mac_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

  localparam int MAC_PRODUCT_WIDTH = 16;
  localparam int MAC_ACC_WIDTH     = 24;

endpackage

// File: rtl/sat_adder.sv
// Unsigned saturating adder, purely combinational.
//   a_i, b_i   : ACC_WIDTH-bit unsigned operands
//   sum_o      : a_i + b_i, clamped to all-ones on overflow
//   overflow_o : high when the true sum does not fit in ACC_WIDTH bits
module sat_adder #(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 overflow_o
);

  // One extra bit catches the carry out of the unsigned add.
  logic [ACC_WIDTH:0] raw_sum;

  assign raw_sum    = {1'b0, a_i} + {1'b0, b_i};
  assign overflow_o = raw_sum[ACC_WIDTH];
  assign sum_o      = raw_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : raw_sum[ACC_WIDTH-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator fed by the multiplier's unsigned product stream.
// Sums accepted beats into a saturating accumulator and presents one result
// per frame (frame ends on a beat with in_last).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : product beat handshake
//   in_product, in_last   : product value and end-of-frame marker
//   clear                 : drop the partial frame (ignored while a result waits)
//   out_valid/out_ready   : result handshake
//   out_sum               : saturated frame sum
//   out_count             : accepted beats in the frame, saturated
//   out_sat               : sum hit saturation during the frame
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PRODUCT_WIDTH = MAC_PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = MAC_ACC_WIDTH,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PRODUCT_WIDTH-1:0] in_product,
  input  logic                     in_last,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_sum,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic                     out_sat
);

  generate
    if (ACC_WIDTH < PRODUCT_WIDTH) begin : g_width_check
      $error("mac_accumulator: ACC_WIDTH must be >= PRODUCT_WIDTH");
    end
  endgenerate

  mac_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   sat_q, sat_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0]   product_ext;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_ovf;
  logic                   accept;

  // Zero-extend the product; written this way so equal widths need no
  // zero-length replication.
  always_comb begin
    product_ext                      = '0;
    product_ext[PRODUCT_WIDTH-1:0]   = in_product;
  end

  sat_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_adder (
    .a_i        (acc_q),
    .b_i        (product_ext),
    .sum_o      (add_sum),
    .overflow_o (add_ovf)
  );

  assign accept = in_valid && in_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      ACCUM: begin
        // clear wins over a beat offered in the same cycle, even a last beat.
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end else if (accept) begin
          acc_d   = add_sum;
          count_d = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q
                                                     : count_q + COUNT_WIDTH'(1);
          sat_d   = sat_q | add_ovf;
          if (in_last) begin
            state_d     = HOLD;
            out_sum_d   = acc_d;
            out_count_d = count_d;
            out_sat_d   = sat_d;
          end
        end
      end
      HOLD: begin
        // Result is frozen until taken; clear has no effect here.
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs decode from the state register only, so out_ready
  // never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  localparam int PW = 16;
  localparam int AW = 17;
  localparam int CW = 4;
  localparam longint ACC_MAX = (longint'(1) << AW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          in_last;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_sat;

  mac_accumulator #(
    .PRODUCT_WIDTH (PW),
    .ACC_WIDTH     (AW),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  // Frame-level reference: true (unbounded) running sum and beat count of
  // the open frame, plus the expected result while one is pending.
  bit     m_hold;
  longint m_total;
  int     m_n;
  longint e_sum;
  int     e_cnt;
  bit     e_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold  = 1'b0;
    m_total = 0;
    m_n     = 0;
  endtask

  // Apply the model for the current inputs, advance one clock, then check.
  task automatic cycle(input string tag);
    bit done;
    done = 1'b0;
    if (!m_hold) begin
      if (clear) begin
        m_total = 0;
        m_n     = 0;
      end else if (in_valid) begin
        m_total += longint'(in_product);
        m_n++;
        if (in_last) begin
          m_hold  = 1'b1;
          done    = 1'b1;
          e_sat   = (m_total > ACC_MAX);
          e_sum   = e_sat ? ACC_MAX : m_total;
          e_cnt   = (m_n > CNT_MAX) ? CNT_MAX : m_n;
          m_total = 0;
          m_n     = 0;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(!m_hold));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(m_hold));
    if (m_hold) begin
      check({tag, "_sum"}, 32'(out_sum), 32'(e_sum));
      check({tag, "_count"}, 32'(out_count), 32'(e_cnt));
      check({tag, "_sat"}, 32'(out_sat), 32'(e_sat));
    end
    if (done) begin
      frames++;
      $display("frame %0d [%s] sum=%0d count=%0d sat=%0d", frames, tag, out_sum, out_count, out_sat);
    end
  endtask

  task automatic beat(input bit v, input int p, input bit l, input bit c, input bit r,
                      input string tag);
    in_valid   = v;
    in_product = PW'(p);
    in_last    = l;
    clear      = c;
    out_ready  = r;
    cycle(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    e_sum = 0;
    e_cnt = 0;
    e_sat = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    beat(0, 0, 0, 0, 1, "idle");

    // Basic frame 3,5,7
    beat(1, 3, 0, 0, 1, "basic");
    beat(1, 5, 0, 0, 1, "basic");
    beat(1, 7, 1, 0, 1, "basic");
    check("basic_sum_const", 32'(out_sum), 32'd15);
    check("basic_count_const", 32'(out_count), 32'd3);
    beat(0, 0, 0, 0, 1, "basic_hold");
    check("basic_ready_back", 32'(in_ready), 32'd1);

    // Saturation at ACC_WIDTH=17
    beat(1, 65535, 0, 0, 1, "sat");
    beat(1, 65535, 0, 0, 1, "sat");
    beat(1, 2, 1, 0, 0, "sat");
    check("sat_sum_const", 32'(out_sum), 32'd131071);
    check("sat_flag_const", 32'(out_sat), 32'd1);
    beat(0, 0, 0, 0, 1, "sat_hold");

    // Backpressure: result held, offered beats not consumed
    beat(1, 10, 0, 0, 0, "bp");
    beat(1, 20, 1, 0, 0, "bp");
    for (int i = 0; i < 5; i++) beat(1, 99, 1, 0, 0, "bp_stall");
    check("bp_sum_const", 32'(out_sum), 32'd30);
    beat(0, 0, 0, 0, 1, "bp_release");
    beat(1, 1, 1, 0, 0, "bp_next");
    check("bp_next_sum_const", 32'(out_sum), 32'd1);
    beat(0, 0, 0, 0, 1, "bp_next_hold");

    // Clear priority over a last beat
    beat(1, 4, 0, 0, 1, "clr");
    beat(1, 4, 0, 0, 1, "clr");
    beat(1, 9, 1, 1, 1, "clr_drop");
    beat(0, 0, 0, 0, 1, "clr_idle");
    beat(1, 6, 1, 0, 0, "clr_next");
    check("clr_next_sum_const", 32'(out_sum), 32'd6);
    check("clr_next_count_const", 32'(out_count), 32'd1);
    beat(0, 0, 0, 0, 1, "clr_next_hold");

    // Clear while holding a result is ignored
    beat(1, 8, 1, 0, 0, "hclr");
    beat(0, 0, 0, 1, 0, "hclr_pulse");
    beat(0, 0, 0, 0, 0, "hclr_wait");
    check("hclr_sum_const", 32'(out_sum), 32'd8);
    beat(0, 0, 0, 0, 1, "hclr_take");

    // Async reset mid-frame
    beat(1, 100, 0, 0, 1, "arst");
    beat(1, 200, 0, 0, 1, "arst");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_sum", 32'(out_sum), 32'd0);
    check("arst_out_count", 32'(out_count), 32'd0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1, 1, 1, 0, 0, "arst_next");
    check("arst_next_sum_const", 32'(out_sum), 32'd1);
    beat(0, 0, 0, 0, 1, "arst_next_hold");

    // Beat counter saturates at all-ones; zero products still count
    for (int i = 0; i < 19; i++) beat(1, (i % 2), 0, 0, 1, "cnt");
    beat(1, 0, 1, 0, 0, "cnt");
    check("cnt_count_const", 32'(out_count), 32'd15);
    check("cnt_sum_const", 32'(out_sum), 32'd9);
    beat(0, 0, 0, 0, 1, "cnt_hold");

    // Randomized traffic against the frame model
    for (int i = 0; i < 400; i++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                      : int'($urandom_range(0, 255));
      beat(bit'($urandom_range(0, 3) != 0), p, bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)), "rand");
    end
    beat(0, 0, 0, 0, 1, "drain");
    beat(0, 0, 0, 0, 1, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
